// File: rtl/niosii_sys_irq_ctrl.sv
// niosii_sys_irq_ctrl
//   Avalon-MM slave interrupt aggregator sitting between the peripherals
//   (system timer and friends) and the Nios II CPU irq input. Each of up to
//   16 lines is captured as level or rising-edge, held in a pending register,
//   masked by a software enable register and OR-reduced into one registered
//   irq. A vector register reports the lowest-index active line.
//
// Ports
//   clk        in   1        system clock
//   reset_n    in   1        asynchronous active-low reset
//   address    in   3        register select
//   chipselect in   1        slave select
//   write_n    in   1        active-low write strobe
//   writedata  in   16       write data
//   irq_in     in   NUM_IRQ  peripheral irq lines (synchronous, active-high)
//   readdata   out  16       registered read data (1-cycle latency)
//   irq        out  1        registered aggregated interrupt to the CPU
//
// Register map
//   0 PENDING     read pending, write-1-to-clear on edge lines
//   1 ENABLE      read/write
//   2 ENABLE_SET  write-only, reads 0
//   3 ENABLE_CLR  write-only, reads 0
//   4 VECTOR      {1, 11'b0, idx} of lowest active line, else 0
//   5 RAW         registered copy of irq_in
//   6,7           read 0, writes ignored
module niosii_sys_irq_ctrl #(
  parameter int          NUM_IRQ        = 8,
  parameter logic [15:0] EDGE_SENSITIVE = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [NUM_IRQ-1:0] EDGE_MASK = EDGE_SENSITIVE[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] edge_pend;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] enable_nxt;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] edge_clr;
  logic [NUM_IRQ-1:0] wdata;
  logic [15:0]        read_mux;
  logic               wr_en;
  logic               unused_wd;

  // Lowest-index-wins encoding of the active lines.
  function automatic logic [15:0] vector_of(input logic [NUM_IRQ-1:0] act);
    logic [15:0] vec;
    vec = 16'h0000;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i]) vec = {1'b1, 11'b0, 4'(i)};
    end
    return vec;
  endfunction

  // Zero-extend a NUM_IRQ-wide field onto the 16-bit bus.
  function automatic logic [15:0] ext16(input logic [NUM_IRQ-1:0] v);
    return 16'(v);
  endfunction

  assign wr_en     = chipselect && !write_n;
  assign wdata     = writedata[NUM_IRQ-1:0];
  // Bits at or above NUM_IRQ are deliberately dropped on writes.
  assign unused_wd = ^writedata;

  // Edge detection uses the previous-cycle sample, so a line held high
  // produces exactly one set; after reset irq_q is 0, so a line already high
  // is seen as a fresh edge.
  assign edge_set = irq_in & ~irq_q & EDGE_MASK;
  assign edge_clr = (wr_en && address == 3'd0) ? (wdata & EDGE_MASK) : '0;

  // Level lines track the registered input directly; W1C cannot touch them.
  assign pending = (edge_pend & EDGE_MASK) | (irq_q & ~EDGE_MASK);
  assign active  = pending & enable;

  always_comb begin
    enable_nxt = enable;
    if (wr_en) begin
      case (address)
        3'd1:    enable_nxt = wdata;
        3'd2:    enable_nxt = enable | wdata;
        3'd3:    enable_nxt = enable & ~wdata;
        default: enable_nxt = enable;
      endcase
    end
  end

  always_comb begin
    read_mux = 16'h0000;
    case (address)
      3'd0:    read_mux = ext16(pending);
      3'd1:    read_mux = ext16(enable);
      3'd4:    read_mux = vector_of(active);
      3'd5:    read_mux = ext16(irq_q);
      default: read_mux = 16'h0000;
    endcase
  end

  // Register stage: input sample, pending/enable state, bus and irq outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q     <= '0;
      edge_pend <= '0;
      enable    <= '0;
      readdata  <= 16'h0000;
      irq       <= 1'b0;
    end else begin
      irq_q     <= irq_in;
      // Set is applied after clear so a coincident edge wins over W1C.
      edge_pend <= (edge_pend & ~edge_clr) | edge_set;
      enable    <= enable_nxt;
      readdata  <= read_mux;
      irq       <= |active;
    end
  end

endmodule

// File: tb/tb_niosii_sys_irq_ctrl.sv
module tb_niosii_sys_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [2:0]  address_a = '0;
  logic        chipselect_a = 1'b0;
  logic        write_n_a = 1'b1;
  logic [15:0] writedata_a = '0;
  logic [7:0]  irq_in_a = '0;
  logic [15:0] readdata_a;
  logic        irq_a;

  logic [2:0]  address_b = '0;
  logic        chipselect_b = 1'b0;
  logic        write_n_b = 1'b1;
  logic [15:0] writedata_b = '0;
  logic [3:0]  irq_in_b = '0;
  logic [15:0] readdata_b;
  logic        irq_b;

  niosii_sys_irq_ctrl #(.NUM_IRQ(8), .EDGE_SENSITIVE(16'h0004)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address_a), .chipselect(chipselect_a),
    .write_n(write_n_a), .writedata(writedata_a), .irq_in(irq_in_a),
    .readdata(readdata_a), .irq(irq_a));

  niosii_sys_irq_ctrl #(.NUM_IRQ(4), .EDGE_SENSITIVE(16'h0000)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address_b), .chipselect(chipselect_b),
    .write_n(write_n_b), .writedata(writedata_b), .irq_in(irq_in_b),
    .readdata(readdata_b), .irq(irq_b));

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wd;
    logic [7:0]  irqs;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    int          sel;
    logic [15:0] exp_rd;
    logic        exp_irq;
    string       name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(input logic cs, input logic wr, input logic [2:0] addr,
                              input logic [15:0] wd, input logic [7:0] irqs,
                              input logic [15:0] exp_rd, input logic exp_irq);
    vec_t v;
    v.cs = cs; v.wr = wr; v.addr = addr; v.wd = wd; v.irqs = irqs;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Pop the oldest expectation and compare it with what the DUT now shows.
  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.sel == 0) begin
      check_val({e.name, ".rd"}, readdata_a, e.exp_rd);
      check_val({e.name, ".irq"}, {15'b0, irq_a}, {15'b0, e.exp_irq});
    end else begin
      check_val({e.name, ".rd"}, readdata_b, e.exp_rd);
      check_val({e.name, ".irq"}, {15'b0, irq_b}, {15'b0, e.exp_irq});
    end
  endtask

  task automatic step(input int sel, input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      chipselect_a = v.cs; write_n_a = !v.wr; address_a = v.addr;
      writedata_a = v.wd; irq_in_a = v.irqs;
    end else begin
      chipselect_b = v.cs; write_n_b = !v.wr; address_b = v.addr;
      writedata_b = v.wd; irq_in_b = v.irqs[3:0];
    end
    e.sel = sel; e.exp_rd = v.exp_rd; e.exp_irq = v.exp_irq; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    score();
    if (sel == 0) begin
      chipselect_a = 1'b0; write_n_a = 1'b1;
    end else begin
      chipselect_b = 1'b0; write_n_b = 1'b1;
    end
  endtask

  initial begin
    // Reset state: every address reads 0, irq low.
    for (int a = 0; a < 8; a++) tbl.push_back(mk(0, 0, 3'(a), 16'h0, 8'h00, 16'h0000, 0));
    // Level line 0.
    tbl.push_back(mk(1, 1, 3'd1, 16'h0001, 8'h00, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 3'd1, 16'h0000, 8'h01, 16'h0001, 0));
    tbl.push_back(mk(0, 0, 3'd4, 16'h0000, 8'h01, 16'h8000, 1));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h00, 16'h0001, 1));
    tbl.push_back(mk(0, 0, 3'd5, 16'h0000, 8'h00, 16'h0000, 0));
    // Edge line 2: single-cycle pulse latches, W1C clears.
    tbl.push_back(mk(1, 1, 3'd1, 16'h0004, 8'h00, 16'h0001, 0));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h04, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h00, 16'h0004, 1));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h00, 16'h0004, 1));
    tbl.push_back(mk(1, 1, 3'd0, 16'h0004, 8'h00, 16'h0004, 1));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h00, 16'h0000, 0));
    // Edge coinciding with W1C: set wins; held high sets only once.
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h04, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h00, 16'h0004, 1));
    tbl.push_back(mk(1, 1, 3'd0, 16'h0004, 8'h04, 16'h0004, 1));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h04, 16'h0004, 1));
    tbl.push_back(mk(1, 1, 3'd0, 16'h0004, 8'h04, 16'h0004, 1));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h04, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0000, 8'h00, 16'h0000, 0));
    // Lines 3 and 5 (level), set/clear enable, vector priority.
    tbl.push_back(mk(1, 1, 3'd1, 16'h0000, 8'h28, 16'h0004, 0));
    tbl.push_back(mk(1, 1, 3'd2, 16'h0028, 8'h28, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 3'd4, 16'h0000, 8'h28, 16'h8003, 1));
    tbl.push_back(mk(1, 1, 3'd0, 16'h0028, 8'h28, 16'h0028, 1));
    tbl.push_back(mk(1, 1, 3'd3, 16'h0008, 8'h28, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 3'd4, 16'h0000, 8'h28, 16'h8005, 1));
    tbl.push_back(mk(0, 0, 3'd1, 16'h0000, 8'h28, 16'h0020, 1));
    tbl.push_back(mk(0, 0, 3'd5, 16'h0000, 8'h28, 16'h0028, 1));
    // Unused addresses, width masking, write without chipselect.
    tbl.push_back(mk(1, 1, 3'd6, 16'hFFFF, 8'h28, 16'h0000, 1));
    tbl.push_back(mk(1, 1, 3'd7, 16'hFFFF, 8'h28, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 3'd1, 16'h0000, 8'h28, 16'h0020, 1));
    tbl.push_back(mk(1, 1, 3'd1, 16'hFFFF, 8'h28, 16'h0020, 1));
    tbl.push_back(mk(0, 0, 3'd1, 16'h0000, 8'h28, 16'h00FF, 1));
    tbl.push_back(mk(0, 1, 3'd1, 16'h0000, 8'h28, 16'h00FF, 1));
    tbl.push_back(mk(0, 0, 3'd1, 16'h0000, 8'h28, 16'h00FF, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(0, tbl[i], $sformatf("vecA%0d", i));

    // Asynchronous reset mid-cycle while irq is high; edge line 2 and level
    // line 0 are held high across the deassertion.
    @(negedge clk);
    irq_in_a = 8'h05;
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst.irq", {15'b0, irq_a}, 16'h0000);
    check_val("async_rst.rd", readdata_a, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, mk(0, 0, 3'd1, 16'h0000, 8'h05, 16'h0000, 0), "post_rst_enable");
    step(0, mk(0, 0, 3'd0, 16'h0000, 8'h05, 16'h0005, 0), "post_rst_pending");
    step(0, mk(0, 0, 3'd4, 16'h0000, 8'h05, 16'h0000, 0), "post_rst_vector");

    // Narrow instance: NUM_IRQ=4.
    step(1, mk(1, 1, 3'd1, 16'hFFFF, 8'h00, 16'h0000, 0), "n4_wr_enable");
    step(1, mk(0, 0, 3'd1, 16'h0000, 8'h0F, 16'h000F, 0), "n4_enable");
    step(1, mk(0, 0, 3'd5, 16'h0000, 8'h0F, 16'h000F, 1), "n4_raw");
    step(1, mk(0, 0, 3'd4, 16'h0000, 8'h0F, 16'h8000, 1), "n4_vector");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/niosii_sys_irq_ctrl.md
Name: niosII_sys_irq_ctrl

Overview:
- Avalon-MM slave interrupt aggregator between the system timer (and other peripherals) and the Nios II CPU irq input.
- Captures up to 16 peripheral irq lines, level or edge per line, and holds them in a pending register.
- Masks pending with a software enable register, drives one registered irq to the CPU, and exposes a lowest-index-wins vector register.
- Same 16-bit, 3-bit-address, registered-readdata slave style as the timer.

Parameters:
- NUM_IRQ, 8, number of irq inputs used, legal range 1..16. Bits at or above NUM_IRQ read 0 and ignore writes.
- EDGE_SENSITIVE, 16'h0000, per-line mode: 1 = rising-edge captured, 0 = level.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- irq_in  in  NUM_IRQ  peripheral irq lines, synchronous to clk, active-high.
- readdata  out  16  registered read data.
- irq  out  1  registered aggregated interrupt to CPU.

Behaviour:
- Write strobe: wr(a) = chipselect && !write_n && address==a.
- Reset values: all registers 0, including readdata, irq, enable, pending and irq_q.
- irq_q <= irq_in every cycle.
- Level line i: pending[i] = irq_q[i]. W1C writes to this bit are ignored.
- Edge line i:
  - pending[i] sets at the edge when irq_in[i] & ~irq_q[i].
  - wr(0) with writedata[i]=1 clears it.
  - Set and clear in the same cycle: set wins.
  - An input held high sets pending only once.
- Address 0, PENDING: read = pending. Write = W1C on edge bits.
- Address 1, ENABLE: read/write. enable <= writedata[NUM_IRQ-1:0].
- Address 2, ENABLE_SET: write only, enable <= enable | writedata. Reads 0.
- Address 3, ENABLE_CLR: write only, enable <= enable & ~writedata. Reads 0.
- Address 4, VECTOR: read only.
  - Active = pending & enable.
  - If any bit is active: {1'b1, 11'b0, idx[3:0]}, where idx is the lowest active index.
  - If none is active: 16'h0000.
- Address 5, RAW: read = irq_q.
- Addresses 6 and 7: read 0, writes ignored.
- readdata <= read_mux(address) every cycle, independent of chipselect. Read latency is 1 clock.
- irq <= |(pending & enable).
- Latency:
  - irq_in rises before edge N: pending is visible after edge N, irq asserts after edge N+1.
  - Clearing enable or pending at edge M deasserts irq after edge M+1.
- Register reads reflect the state after the preceding edge. Writes take effect at the write edge. A read issued in the cycle after a write sees the new value.
- Reset asserted mid-operation clears all state immediately. A line held high across reset deassertion:
  - edge line: captured, because irq_q restarts at 0;
  - level line: pending after the first edge.

Test Plan:
- Reset, then read addresses 0..7 -> all readdata 16'h0000, irq=0.
- Level line 0 (EDGE_SENSITIVE=0), write ENABLE=0x0001, raise irq_in[0] -> irq=1 two edges later; VECTOR=16'h8000; drop irq_in[0] -> irq=0 two edges later.
- EDGE_SENSITIVE=16'h0004, pulse irq_in[2] for 1 cycle with enable=0x0004 -> PENDING=0x0004, irq latched high; write PENDING=0x0004 -> irq=0 after two edges; repeat with an irq_in[2] rising edge in the same cycle as the W1C -> pending stays 1.
- Lines 3 and 5 pending, ENABLE_SET 0x0028 -> VECTOR=16'h8003; ENABLE_CLR 0x0008 -> VECTOR=16'h8005, ENABLE reads 0x0020.
- NUM_IRQ=4: write ENABLE=0xFFFF -> ENABLE reads 0x000F; RAW bits 15:4 always 0.
- Assert reset_n=0 mid-cycle while irq=1 -> irq, readdata, enable and pending all 0 immediately, without waiting for a clock edge.
